// File: rtl/bw_token_cfg_ctrl.sv
// bw_token_cfg_ctrl: central configuration controller for NUM_SHAPERS AXI4
// bandwidth shapers sharing one memory port. Software fills shadow registers;
// a commit sums the shadow update rates, rejects the commit if the sum exceeds
// upd_budget, and otherwise copies every shadow entry to the live outputs in a
// single cycle.
//
// Optional feature macro: BW_CFG_QUIESCE_EN. When defined, a QUIESCE state sits
// between CHECK and APPLY and waits (bounded by QUIESCE_TIMEOUT) until every
// shaper whose entry is about to change reports idle.
//
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   cfg_wr_en/idx    shadow write strobe and entry index
//   cfg_wr_init/upd  shadow init_token / upd_token values
//   cfg_commit       commit request pulse
//   upd_budget       maximum legal sum of all upd_token values
//   shaper_idle      per-shaper idle indication (used only with the macro)
//   init_token       live init values, entry i at [i*IW +: IW]
//   upd_token        live update rates, entry i at [i*UW +: UW]
//   busy             high whenever the controller is not in IDLE
//   commit_done      one-cycle pulse when a commit is applied
//   commit_err       one-cycle pulse when a commit is rejected or aborted
//   cfg_wr_err       one-cycle pulse when a shadow write is dropped
//   upd_sum          sum computed by the last completed check
module bw_token_cfg_ctrl #(
  parameter int unsigned NUM_SHAPERS            = 4,
  parameter int unsigned TOKEN_COUNT_INT_WIDTH  = 16,
  parameter int unsigned TOKEN_COUNT_FRAC_WIDTH = 8,
  parameter int unsigned QUIESCE_TIMEOUT        = 1023,
  localparam int unsigned IW = TOKEN_COUNT_INT_WIDTH,
  localparam int unsigned UW = TOKEN_COUNT_FRAC_WIDTH + 1,
  localparam int unsigned XW = $clog2(NUM_SHAPERS),
  localparam int unsigned SW = UW + XW
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cfg_wr_en,
  input  logic [XW-1:0]             cfg_wr_idx,
  input  logic [IW-1:0]             cfg_wr_init,
  input  logic [UW-1:0]             cfg_wr_upd,
  input  logic                      cfg_commit,
  input  logic [SW-1:0]             upd_budget,
  input  logic [NUM_SHAPERS-1:0]    shaper_idle,
  output logic [NUM_SHAPERS*IW-1:0] init_token,
  output logic [NUM_SHAPERS*UW-1:0] upd_token,
  output logic                      busy,
  output logic                      commit_done,
  output logic                      commit_err,
  output logic                      cfg_wr_err,
  output logic [SW-1:0]             upd_sum
);

  // Widened so the comparison stays correct when NUM_SHAPERS is a power of two.
  localparam logic [XW:0] NUM_L = (XW+1)'(NUM_SHAPERS);
  localparam logic [XW-1:0] LAST_IDX = XW'(NUM_SHAPERS - 1);

`ifdef BW_CFG_QUIESCE_EN
  localparam int unsigned CW = $clog2(QUIESCE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(QUIESCE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SUM, S_CHECK, S_QUIESCE, S_APPLY
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SUM, S_CHECK, S_APPLY
  } state_t;
`endif

  state_t state_q, state_d;

  logic [IW-1:0] sh_init_q   [NUM_SHAPERS];
  logic [UW-1:0] sh_upd_q    [NUM_SHAPERS];
  logic [IW-1:0] live_init_q [NUM_SHAPERS];
  logic [UW-1:0] live_upd_q  [NUM_SHAPERS];

  logic [SW-1:0] acc_q, acc_d;
  logic [XW-1:0] idx_q, idx_d;
  logic          pass_q, pass_d;
  logic [SW-1:0] upd_sum_q, upd_sum_d;
  logic          busy_d, done_d, err_d, wr_err_d;
  logic          wr_ok, apply;
  logic          idx_ok;
  logic [SW-1:0] sum_next;

  assign idx_ok   = {1'b0, cfg_wr_idx} < NUM_L;
  assign sum_next = acc_q + SW'(sh_upd_q[idx_q]);

`ifdef BW_CFG_QUIESCE_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          all_ready;

  // Every shaper whose entry is about to change must be idle.
  always_comb begin
    all_ready = 1'b1;
    for (int i = 0; i < int'(NUM_SHAPERS); i++) begin
      if (((sh_init_q[i] != live_init_q[i]) || (sh_upd_q[i] != live_upd_q[i]))
          && !shaper_idle[i])
        all_ready = 1'b0;
    end
  end
`else
  logic unused_idle;
  localparam int unsigned unused_timeout = QUIESCE_TIMEOUT;
  assign unused_idle = ^shaper_idle;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    upd_sum_d = upd_sum_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_err_d  = 1'b0;
    wr_ok     = 1'b0;
    apply     = 1'b0;
`ifdef BW_CFG_QUIESCE_EN
    cnt_d     = cnt_q;
`endif

    // Writes land only in IDLE with a legal index; anything else is dropped.
    if (cfg_wr_en) begin
      if ((state_q == S_IDLE) && idx_ok) wr_ok    = 1'b1;
      else                               wr_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_commit) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        acc_d = sum_next;
        idx_d = idx_q + XW'(1);
        // The budget decision is made on the final add so the CHECK cycle
        // already carries upd_sum and any rejection pulse.
        if (idx_q == LAST_IDX) begin
          state_d   = S_CHECK;
          upd_sum_d = sum_next;
          pass_d    = (sum_next <= upd_budget);
          err_d     = (sum_next > upd_budget);
        end
      end
      S_CHECK: begin
        if (!pass_q) begin
          state_d = S_IDLE;
        end else begin
`ifdef BW_CFG_QUIESCE_EN
          state_d = S_QUIESCE;
          cnt_d   = '0;
`else
          state_d = S_APPLY;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef BW_CFG_QUIESCE_EN
      S_QUIESCE: begin
        if (all_ready) begin
          state_d = S_APPLY;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_APPLY: begin
        apply   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      pass_q      <= 1'b0;
      upd_sum_q   <= '0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      commit_err  <= 1'b0;
      cfg_wr_err  <= 1'b0;
`ifdef BW_CFG_QUIESCE_EN
      cnt_q       <= '0;
`endif
      for (int i = 0; i < int'(NUM_SHAPERS); i++) begin
        sh_init_q[i]   <= '0;
        sh_upd_q[i]    <= '0;
        live_init_q[i] <= '0;
        live_upd_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      upd_sum_q   <= upd_sum_d;
      busy        <= busy_d;
      commit_done <= done_d;
      commit_err  <= err_d;
      cfg_wr_err  <= wr_err_d;
`ifdef BW_CFG_QUIESCE_EN
      cnt_q       <= cnt_d;
`endif
      if (wr_ok) begin
        sh_init_q[cfg_wr_idx] <= cfg_wr_init;
        sh_upd_q[cfg_wr_idx]  <= cfg_wr_upd;
      end
      // Unchanged entries are rewritten with the same value, so no glitch.
      if (apply) begin
        for (int i = 0; i < int'(NUM_SHAPERS); i++) begin
          live_init_q[i] <= sh_init_q[i];
          live_upd_q[i]  <= sh_upd_q[i];
        end
      end
    end
  end

  assign upd_sum = upd_sum_q;

  // Pack the live entries onto the flat output buses.
  for (genvar g = 0; g < int'(NUM_SHAPERS); g++) begin : g_pack
    assign init_token[g*IW +: IW] = live_init_q[g];
    assign upd_token[g*UW +: UW]  = live_upd_q[g];
  end

endmodule
